// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM for the MIPS-subset datapath
module multicycle_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instruction,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_source,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_reg,
   output logic             halted,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MEM_ADDR = 4'd3;
   localparam logic [3:0] S_MEM_RD   = 4'd4;
   localparam logic [3:0] S_MEM_WB   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_R_EXEC   = 4'd7;
   localparam logic [3:0] S_R_WB     = 4'd8;
   localparam logic [3:0] S_I_EXEC   = 4'd9;
   localparam logic [3:0] S_I_WB     = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_HALT     = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_HALT  = 6'h3f;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [3:0] state_next;
   logic       retire;
   logic       set_illegal;
   logic       unused_fields;

   assign opcode        = instruction[31:26];
   assign funct         = instruction[5:0];
   assign unused_fields = ^instruction[25:6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         instr_count <= '0;
         illegal     <= 1'b0;
      end else begin
         state <= state_next;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
         if (set_illegal)
            illegal <= 1'b1;
      end
   end

   // retire marks the transition that completes an instruction
   always_comb begin
      state_next  = state;
      retire      = 1'b0;
      set_illegal = 1'b0;
      case (state)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_ADD || funct == FN_SLT) begin
                     state_next = S_R_EXEC;
                  end else begin
                     state_next  = S_HALT;
                     set_illegal = 1'b1;
                  end
               end
               OP_ADDI:       state_next = S_I_EXEC;
               OP_LW, OP_SW:  state_next = S_MEM_ADDR;
               OP_BEQ:        state_next = S_BRANCH;
               OP_J:          state_next = S_JUMP;
               OP_HALT: begin
                  state_next = S_HALT;
                  retire     = 1'b1;
               end
               default: begin
                  state_next  = S_HALT;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
         S_MEM_WR: begin
            if (mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_R_EXEC: state_next = S_R_WB;
         S_I_EXEC: state_next = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_or_d    = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      pc_source = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = 3'd0;
      reg_write = 1'b0;
      reg_dst   = 1'b0;
      mem_reg   = 1'b0;
      halted    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE:   alu_src_b = 2'd3;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write = 1'b1;
            mem_reg   = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = (funct == FN_SLT) ? 3'd4 : 3'd0;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_I_WB:   reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'd6;
            pc_source = 2'd1;
            pc_en     = zero;
         end
         S_JUMP: begin
            pc_source = 2'd2;
            pc_en     = 1'b1;
         end
         S_HALT:   halted = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - bench for multicycle_controller
module tb_multicycle_controller;

   localparam int CNT_W = 4;

   localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2, ST_MEM_ADDR = 4'd3;
   localparam logic [3:0] ST_MEM_RD = 4'd4, ST_MEM_WB = 4'd5, ST_MEM_WR = 4'd6, ST_R_EXEC = 4'd7;
   localparam logic [3:0] ST_R_WB = 4'd8,  ST_I_EXEC = 4'd9, ST_I_WB = 4'd10,  ST_BRANCH = 4'd11;
   localparam logic [3:0] ST_JUMP = 4'd12, ST_HALT = 4'd13;

   // expected-control bit positions, same order as obs_ctrl below
   localparam logic [16:0] MR = 17'h10000, MW = 17'h08000, IOD = 17'h04000, IRW = 17'h02000;
   localparam logic [16:0] PCE = 17'h01000, ASA = 17'h00200, RW = 17'h00008, RDST = 17'h00004;
   localparam logic [16:0] MREG = 17'h00002, HLT = 17'h00001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      instruction = '0;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b0;
   logic             mem_read, mem_write, i_or_d, ir_write, pc_en;
   logic [1:0]       pc_source, alu_src_b;
   logic             alu_src_a, reg_write, reg_dst, mem_reg, halted, illegal;
   logic [2:0]       alu_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;
   logic [16:0]      obs_ctrl;

   int ncmp = 0;
   int nfail = 0;
   int model_cnt = 0;
   logic model_ill = 1'b0;

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
      .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_reg(mem_reg),
      .halted(halted), .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign obs_ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                      alu_src_b, alu_op, reg_write, reg_dst, mem_reg, halted};

   function automatic logic [16:0] f_ps(input int v);
      return 17'(v) << 10;
   endfunction
   function automatic logic [16:0] f_asb(input int v);
      return 17'(v) << 7;
   endfunction
   function automatic logic [16:0] f_op(input int v);
      return 17'(v) << 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive mem_ready, check everything mid-cycle, then account for the edge
   task automatic step(input logic [3:0] es, input logic [16:0] ec, input logic rdy,
                       input logic ret, input logic ill, input string tag);
      mem_ready = rdy;
      @(negedge clk);
      chk({tag, "_state"}, 32'(state), 32'(es));
      chk({tag, "_ctrl"}, 32'(obs_ctrl), 32'(ec));
      chk({tag, "_count"}, 32'(instr_count), 32'(model_cnt % (1 << CNT_W)));
      chk({tag, "_illegal"}, 32'(illegal), 32'(model_ill));
      @(posedge clk);
      #1;
      if (ret) model_cnt++;
      if (ill) model_ill = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'($urandom);
      @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'(ST_IDLE));
      chk("reset_ctrl", 32'(obs_ctrl), 32'h0);
      chk("reset_count", 32'(instr_count), 32'h0);
      chk("reset_illegal", 32'(illegal), 32'h0);
      rst_n = 1'b1;
      model_cnt = 0;
      model_ill = 1'b0;
      step(ST_IDLE, 17'h0, 1'($urandom), 1'b0, 1'b0, "idle");
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw);
      logic [5:0] op;
      logic [5:0] fn;
      logic r_ok;
      logic legal;
      op = ins[31:26];
      fn = ins[5:0];
      r_ok = (op == 6'h00) && (fn == 6'h20 || fn == 6'h2a);
      legal = r_ok || op == 6'h08 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
              op == 6'h02 || op == 6'h3f;
      instruction = ins;
      zero = z;
      for (int i = 0; i < fw; i++)
         step(ST_FETCH, MR | f_asb(1), 1'b0, 1'b0, 1'b0, "fetch_wait");
      step(ST_FETCH, MR | IRW | PCE | f_asb(1), 1'b1, 1'b0, 1'b0, "fetch");
      step(ST_DECODE, f_asb(3), 1'($urandom), op == 6'h3f, !legal, "decode");
      if (!legal || op == 6'h3f) begin
         for (int i = 0; i < 3; i++)
            step(ST_HALT, HLT, 1'($urandom), 1'b0, 1'b0, "halt");
      end else if (r_ok) begin
         step(ST_R_EXEC, ASA | f_op(fn == 6'h2a ? 4 : 0), 1'($urandom), 1'b0, 1'b0, "r_exec");
         step(ST_R_WB, RW | RDST, 1'($urandom), 1'b1, 1'b0, "r_wb");
      end else if (op == 6'h08) begin
         step(ST_I_EXEC, ASA | f_asb(2), 1'($urandom), 1'b0, 1'b0, "i_exec");
         step(ST_I_WB, RW, 1'($urandom), 1'b1, 1'b0, "i_wb");
      end else if (op == 6'h23) begin
         step(ST_MEM_ADDR, ASA | f_asb(2), 1'($urandom), 1'b0, 1'b0, "lw_addr");
         for (int i = 0; i < mw; i++)
            step(ST_MEM_RD, MR | IOD, 1'b0, 1'b0, 1'b0, "lw_wait");
         step(ST_MEM_RD, MR | IOD, 1'b1, 1'b0, 1'b0, "lw_rd");
         step(ST_MEM_WB, RW | MREG, 1'($urandom), 1'b1, 1'b0, "lw_wb");
      end else if (op == 6'h2b) begin
         step(ST_MEM_ADDR, ASA | f_asb(2), 1'($urandom), 1'b0, 1'b0, "sw_addr");
         for (int i = 0; i < mw; i++)
            step(ST_MEM_WR, MW | IOD, 1'b0, 1'b0, 1'b0, "sw_wait");
         step(ST_MEM_WR, MW | IOD, 1'b1, 1'b1, 1'b0, "sw_wr");
      end else if (op == 6'h04) begin
         step(ST_BRANCH, ASA | f_op(6) | f_ps(1) | (z ? PCE : 17'h0), 1'($urandom),
              1'b1, 1'b0, "beq");
      end else begin
         step(ST_JUMP, PCE | f_ps(2), 1'($urandom), 1'b1, 1'b0, "jump");
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
      return {op, 20'($urandom), fn};
   endfunction

   function automatic logic [5:0] rnd_illegal_op();
      logic [5:0] op;
      do op = 6'($urandom);
      while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
             op == 6'h02 || op == 6'h3f);
      return op;
   endfunction

   initial begin
      int k;
      logic [5:0] bad_fn;

      do_reset();

      run_instr(mk(6'h00, 6'h20), 1'b0, 3, 0);
      run_instr(mk(6'h00, 6'h2a), 1'b0, 0, 0);
      chk("count_after_r", 32'(instr_count), 32'd2);
      run_instr(mk(6'h23, 6'h00), 1'b0, 0, 2);
      run_instr(mk(6'h2b, 6'h00), 1'b0, 0, 2);
      run_instr(mk(6'h04, 6'h00), 1'b1, 0, 0);
      run_instr(mk(6'h04, 6'h00), 1'b0, 0, 0);
      run_instr(mk(6'h02, 6'h00), 1'b0, 0, 0);
      chk("count_after_mix", 32'(instr_count), 32'd7);

      run_instr(mk(6'h3f, 6'h00), 1'b0, 0, 0);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_count", 32'(instr_count), 32'd8);
      do_reset();
      run_instr(mk(6'h11, 6'h00), 1'b0, 0, 0);
      chk("illegal_op", 32'(illegal), 32'd1);
      chk("illegal_op_count", 32'(instr_count), 32'd0);
      do_reset();
      run_instr(mk(6'h00, 6'h22), 1'b0, 1, 0);
      chk("illegal_funct", 32'(illegal), 32'd1);
      do_reset();

      // reset arriving while a load is waiting on memory
      run_instr(mk(6'h02, 6'h00), 1'b0, 0, 0);
      instruction = mk(6'h23, 6'h00);
      step(ST_FETCH, MR | IRW | PCE | f_asb(1), 1'b1, 1'b0, 1'b0, "abort_fetch");
      step(ST_DECODE, f_asb(3), 1'b0, 1'b0, 1'b0, "abort_decode");
      step(ST_MEM_ADDR, ASA | f_asb(2), 1'b0, 1'b0, 1'b0, "abort_addr");
      step(ST_MEM_RD, MR | IOD, 1'b0, 1'b0, 1'b0, "abort_rd");
      @(negedge clk);
      chk("abort_pre_read", 32'(mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_read", 32'(mem_read), 32'd0);
      chk("abort_state", 32'(state), 32'(ST_IDLE));
      chk("abort_count", 32'(instr_count), 32'd0);
      do_reset();

      for (int i = 0; i < 16; i++)
         run_instr(mk(6'h02, 6'h00), 1'b0, 0, 0);
      chk("wrap_count", 32'(instr_count), 32'd0);

      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 17);
         bad_fn = 6'($urandom);
         if (bad_fn == 6'h20 || bad_fn == 6'h2a) bad_fn = 6'h22;
         case (k)
            0, 1:        run_instr(mk(6'h00, 6'h20), 1'($urandom), $urandom_range(0, 3), 0);
            2, 3:        run_instr(mk(6'h00, 6'h2a), 1'($urandom), $urandom_range(0, 3), 0);
            4, 5:        run_instr(mk(6'h08, 6'($urandom)), 1'($urandom), $urandom_range(0, 3), 0);
            6, 7:        run_instr(mk(6'h23, 6'($urandom)), 1'($urandom), $urandom_range(0, 3),
                                   $urandom_range(0, 3));
            8, 9:        run_instr(mk(6'h2b, 6'($urandom)), 1'($urandom), $urandom_range(0, 3),
                                   $urandom_range(0, 3));
            10, 11:      run_instr(mk(6'h04, 6'($urandom)), 1'($urandom), $urandom_range(0, 3), 0);
            12, 13, 14:  run_instr(mk(6'h02, 6'($urandom)), 1'($urandom), $urandom_range(0, 3), 0);
            15:          run_instr(mk(6'h3f, 6'($urandom)), 1'($urandom), $urandom_range(0, 3), 0);
            16:          run_instr(mk(rnd_illegal_op(), 6'($urandom)), 1'($urandom), 0, 0);
            default:     run_instr(mk(6'h00, bad_fn), 1'($urandom), 0, 0);
         endcase
         if (k >= 15) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
